// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/stall controller.
`default_nettype none

package hazard_pkg;

  localparam int HZ_W = 3;

  typedef enum logic [HZ_W-1:0] {
    HZ_NONE     = 3'd0,
    HZ_LOAD_USE = 3'd1,
    HZ_RAW      = 3'd2,
    HZ_WAW      = 3'd3,
    HZ_FULL     = 3'd4
  } hz_cause_t;

endpackage

`default_nettype wire

// File: rtl/sb_pending_tracker.sv
// Per-register pending bits and outstanding long-op counter with a sticky
// underflow error flag.
`default_nettype none

module sb_pending_tracker
  import hazard_pkg::*;
#(
  parameter int REG_NUM   = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en_i,
  input  logic [ADDR_W-1:0]  set_addr_i,
  input  logic               inc_i,
  input  logic               clr_en_i,
  input  logic [ADDR_W-1:0]  clr_addr_i,
  output logic [REG_NUM-1:0] pending_o,
  output logic [CNT_W-1:0]   outst_cnt_o,
  output logic               sb_err_o
);

  logic [REG_NUM-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  always_comb begin
    pending_d = pending_q;
    // Set is applied after clear so a same-register collision leaves it pending.
    for (int i = 1; i < REG_NUM; i++) begin
      if (clr_en_i && (clr_addr_i == ADDR_W'(i))) pending_d[i] = 1'b0;
      if (set_en_i && (set_addr_i == ADDR_W'(i))) pending_d[i] = 1'b1;
    end
    pending_d[0] = 1'b0;

    cnt_d = cnt_q;
    unique case ({inc_i, clr_en_i})
      2'b10: if (cnt_q != CNT_W'(MAX_OUTST)) cnt_d = cnt_q + 1'b1;
      2'b01: if (cnt_q != '0)                cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    err_d = err_q | (clr_en_i && (cnt_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign pending_o   = pending_q;
  assign outst_cnt_o = cnt_q;
  assign sb_err_o    = err_q;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector: load-use, scoreboard RAW/WAW, long-op saturation
// and taken-branch flush, driving PC, IF/ID and ID/EX control.
`default_nettype none

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_NUM   = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_OUTST = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             id_valid,
  input  logic [ADDR_W-1:0]                id_rs1_addr,
  input  logic [ADDR_W-1:0]                id_rs2_addr,
  input  logic                             id_rs1_used,
  input  logic                             id_rs2_used,
  input  logic [ADDR_W-1:0]                id_rd_addr,
  input  logic                             id_rd_write,
  input  logic                             id_long_op,
  input  logic                             ex_mem_read,
  input  logic [ADDR_W-1:0]                ex_rd_addr,
  input  logic                             wb_long_valid,
  input  logic [ADDR_W-1:0]                wb_long_rd_addr,
  input  logic                             branch_taken,
  output logic                             pc_stall,
  output logic                             if_id_stall,
  output logic                             id_ex_bubble,
  output logic                             if_id_flush,
  output logic                             id_ex_flush,
  output logic [HZ_W-1:0]                  stall_cause,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outst_cnt,
  output logic                             sb_err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [REG_NUM-1:0] w_pending;
  logic               w_rs1_nz, w_rs2_nz, w_rd_nz;
  logic               w_load_use, w_raw, w_waw, w_full;
  logic               w_rs1_busy, w_rs2_busy, w_rd_busy;
  hz_cause_t          w_cause;
  logic               w_hazard, w_issue;

  assign w_rs1_nz = id_rs1_used && (id_rs1_addr != '0);
  assign w_rs2_nz = id_rs2_used && (id_rs2_addr != '0);
  assign w_rd_nz  = id_rd_write && (id_rd_addr  != '0);

  // A register completing this cycle is forwarded from MEM/WB, so it no longer blocks.
  assign w_rs1_busy = w_pending[id_rs1_addr] &&
                      !(wb_long_valid && (wb_long_rd_addr == id_rs1_addr));
  assign w_rs2_busy = w_pending[id_rs2_addr] &&
                      !(wb_long_valid && (wb_long_rd_addr == id_rs2_addr));
  assign w_rd_busy  = w_pending[id_rd_addr] &&
                      !(wb_long_valid && (wb_long_rd_addr == id_rd_addr));

  assign w_load_use = ex_mem_read && (ex_rd_addr != '0) &&
                      ((w_rs1_nz && (id_rs1_addr == ex_rd_addr)) ||
                       (w_rs2_nz && (id_rs2_addr == ex_rd_addr)));
  assign w_raw      = (w_rs1_nz && w_rs1_busy) || (w_rs2_nz && w_rs2_busy);
  assign w_waw      = w_rd_nz && w_rd_busy;
  // A completion in the same cycle frees a slot for the incoming long op.
  assign w_full     = id_long_op && (outst_cnt == CNT_W'(MAX_OUTST)) && !wb_long_valid;

  always_comb begin
    w_cause = HZ_NONE;
    if (id_valid) begin
      if (w_load_use)  w_cause = HZ_LOAD_USE;
      else if (w_raw)  w_cause = HZ_RAW;
      else if (w_waw)  w_cause = HZ_WAW;
      else if (w_full) w_cause = HZ_FULL;
    end
  end

  assign w_hazard = (w_cause != HZ_NONE);
  assign w_issue  = id_valid && !w_hazard && !branch_taken;

  always_comb begin
    pc_stall     = w_hazard && !branch_taken;
    if_id_stall  = pc_stall;
    id_ex_bubble = pc_stall;
    if_id_flush  = branch_taken;
    id_ex_flush  = branch_taken;
    stall_cause  = branch_taken ? HZ_NONE : w_cause;
  end

  sb_pending_tracker #(
    .REG_NUM   (REG_NUM),
    .ADDR_W    (ADDR_W),
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en_i    (w_issue && id_long_op && w_rd_nz),
    .set_addr_i  (id_rd_addr),
    .inc_i       (w_issue && id_long_op),
    .clr_en_i    (wb_long_valid),
    .clr_addr_i  (wb_long_rd_addr),
    .pending_o   (w_pending),
    .outst_cnt_o (outst_cnt),
    .sb_err_o    (sb_err)
  );

endmodule

`default_nettype wire
